// File: rtl/unified_mem_ctrl.sv
// Sequencer that serialises instruction fetch and data access of a
// single-cycle RISC-V core onto one shared variable-latency memory port.
module unified_mem_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o,
  output logic [31:0] retire_cnt_o
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DATA,
    STEP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] data_q, data_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;

  logic ack;
  logic tmo;

  // acks are only meaningful while a request is outstanding
  assign ack = req_q & mem_ack_i;
  assign tmo = req_q & ~mem_ack_i & (wait_q == WLAST);

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    data_d  = data_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wait_d  = (req_q && !ack) ? wait_q + 1'b1 : '0;
    unique case (state_q)
      IDLE: begin
        if (inst_ce_i) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = inst_addr_i;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (ack) begin
          inst_d  = mem_rdata_i;
          req_d   = 1'b0;
          state_d = DECODE;
        end else if (tmo) begin
          inst_d  = NOP_INST;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (data_ce_i) begin
          addr_d  = data_addr_i;
          we_d    = data_we_i;
          wdata_d = data_i;
          req_d   = 1'b1;
          state_d = DATA;
        end else begin
          state_d = STEP;
        end
      end
      DATA: begin
        if (ack) begin
          if (!we_q) data_d = mem_rdata_i;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = STEP;
        end else if (tmo) begin
          if (!we_q) data_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        cnt_d = cnt_q + 32'd1;
        if (inst_ce_i) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = inst_addr_i;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= NOP_INST;
      data_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign inst_o       = inst_q;
  assign data_o       = data_q;
  assign core_stall_o = (state_q != STEP);
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign err_o        = err_q;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: fetch/load/store sequencing,
// timeouts, ack-in-abort-cycle, spurious acks and mid-transfer reset.
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;
  logic [31:0] retire_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  unified_mem_ctrl #(
    .MAX_WAIT(4),
    .NOP_INST(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_ce_i   (inst_ce_i),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .core_stall_o(core_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .err_o       (err_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first request cycle; acks after `waits` idle cycles.
  task automatic mem_xfer(input int waits, input logic [31:0] rd);
    for (int i = 0; i < waits; i++) begin
      chk("xfer_req_wait", 32'(mem_req_o), 32'd1);
      tick();
    end
    chk("xfer_req_ack", 32'(mem_req_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hX;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    inst_ce_i   = 1'b0;
    inst_addr_i = '0;
    data_ce_i   = 1'b0;
    data_we_i   = 1'b0;
    data_addr_i = '0;
    data_i      = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    #1;
    do_reset();

    chk("rst_inst", inst_o, NOP);
    chk("rst_data", data_o, 32'h0);
    chk("rst_stall", 32'(core_stall_o), 32'd1);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cnt", retire_cnt_o, 32'd0);

    // zero-wait ALU instruction
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h0;
    tick();
    chk("alu_c1_req", 32'(mem_req_o), 32'd1);
    chk("alu_c1_addr", mem_addr_o, 32'h0);
    chk("alu_c1_stall", 32'(core_stall_o), 32'd1);
    inst_ce_i = 1'b0;
    mem_xfer(0, 32'h00208033);
    chk("alu_c2_inst", inst_o, 32'h00208033);
    chk("alu_c2_req", 32'(mem_req_o), 32'd0);
    chk("alu_c2_stall", 32'(core_stall_o), 32'd1);
    tick();
    chk("alu_c3_stall", 32'(core_stall_o), 32'd0);
    chk("alu_c3_cnt", retire_cnt_o, 32'd0);
    tick();
    chk("alu_end_stall", 32'(core_stall_o), 32'd1);
    chk("alu_end_cnt", retire_cnt_o, 32'd1);
    chk("alu_end_req", 32'(mem_req_o), 32'd0);

    // load with 2 wait cycles per phase: 8 cycles
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h04;
    tick();
    inst_ce_i = 1'b0;
    chk("ld_f_addr", mem_addr_o, 32'h04);
    chk("ld_f_we", 32'(mem_we_o), 32'd0);
    mem_xfer(2, 32'h10002083);
    chk("ld_dec_inst", inst_o, 32'h10002083);
    chk("ld_dec_gap", 32'(mem_req_o), 32'd0);
    data_ce_i   = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h100;
    tick();
    data_ce_i = 1'b0;
    chk("ld_d_addr", mem_addr_o, 32'h100);
    chk("ld_d_we", 32'(mem_we_o), 32'd0);
    mem_xfer(2, 32'hDEADBEEF);
    chk("ld_c8_stall", 32'(core_stall_o), 32'd0);
    chk("ld_c8_data", data_o, 32'hDEADBEEF);
    chk("ld_c8_req", 32'(mem_req_o), 32'd0);
    tick();
    chk("ld_end_cnt", retire_cnt_o, 32'd2);

    // store, 1 wait cycle on the data phase
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h08;
    tick();
    inst_ce_i = 1'b0;
    mem_xfer(0, 32'h0020A023);
    chk("st_gap", 32'(mem_req_o), 32'd0);
    data_ce_i   = 1'b1;
    data_we_i   = 1'b1;
    data_addr_i = 32'h200;
    data_i      = 32'h12345678;
    tick();
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
    data_i    = 32'h0;
    chk("st_addr", mem_addr_o, 32'h200);
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_wdata", mem_wdata_o, 32'h12345678);
    tick();
    chk("st_wait_we", 32'(mem_we_o), 32'd1);
    chk("st_wait_wdata", mem_wdata_o, 32'h12345678);
    mem_xfer(0, 32'hCAFEF00D);
    chk("st_step_stall", 32'(core_stall_o), 32'd0);
    chk("st_step_data", data_o, 32'hDEADBEEF);
    chk("st_step_we", 32'(mem_we_o), 32'd0);
    tick();
    chk("st_end_cnt", retire_cnt_o, 32'd3);

    // fetch timeout after 4 request cycles
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h0C;
    tick();
    inst_ce_i = 1'b0;
    tick();
    tick();
    tick();
    chk("to_c4_req", 32'(mem_req_o), 32'd1);
    chk("to_c4_err", 32'(err_o), 32'd0);
    tick();
    chk("to_abort_req", 32'(mem_req_o), 32'd0);
    chk("to_abort_err", 32'(err_o), 32'd1);
    chk("to_abort_inst", inst_o, NOP);
    chk("to_abort_stall", 32'(core_stall_o), 32'd1);
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h10;
    tick();
    chk("to_step_stall", 32'(core_stall_o), 32'd0);
    tick();
    inst_ce_i = 1'b0;
    chk("to_next_addr", mem_addr_o, 32'h10);
    chk("to_next_cnt", retire_cnt_o, 32'd4);
    mem_xfer(0, 32'h00000033);
    chk("to_next_inst", inst_o, 32'h00000033);
    chk("to_next_err", 32'(err_o), 32'd1);

    // data timeout on a load clears data_o
    data_ce_i   = 1'b1;
    data_addr_i = 32'h300;
    tick();
    data_ce_i = 1'b0;
    tick();
    tick();
    tick();
    chk("dto_c4_req", 32'(mem_req_o), 32'd1);
    tick();
    chk("dto_step_stall", 32'(core_stall_o), 32'd0);
    chk("dto_data", data_o, 32'h0);
    chk("dto_req", 32'(mem_req_o), 32'd0);
    tick();
    chk("dto_cnt", retire_cnt_o, 32'd5);

    do_reset();
    chk("rst2_err", 32'(err_o), 32'd0);
    chk("rst2_cnt", retire_cnt_o, 32'd0);

    // ack in the abort cycle completes normally
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h14;
    tick();
    inst_ce_i = 1'b0;
    mem_xfer(3, 32'h00100093);
    chk("late_ack_inst", inst_o, 32'h00100093);
    chk("late_ack_err", 32'(err_o), 32'd0);
    tick();
    chk("late_ack_stall", 32'(core_stall_o), 32'd0);
    tick();

    // spurious ack while idle
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    tick();
    tick();
    mem_ack_i = 1'b0;
    chk("spur_req", 32'(mem_req_o), 32'd0);
    chk("spur_stall", 32'(core_stall_o), 32'd1);
    chk("spur_inst", inst_o, 32'h00100093);
    chk("spur_cnt", retire_cnt_o, 32'd1);
    chk("spur_err", 32'(err_o), 32'd0);

    // reset while DATA waits for ack
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h18;
    tick();
    mem_xfer(0, 32'h40002103);
    data_ce_i   = 1'b1;
    data_addr_i = 32'h400;
    tick();
    data_ce_i = 1'b0;
    chk("mrst_data_req", 32'(mem_req_o), 32'd1);
    chk("mrst_data_addr", mem_addr_o, 32'h400);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req", 32'(mem_req_o), 32'd0);
    chk("mrst_cnt", retire_cnt_o, 32'd0);
    chk("mrst_inst", inst_o, NOP);
    inst_ce_i   = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    tick();
    mem_ack_i = 1'b0;
    chk("mrst_ack_req", 32'(mem_req_o), 32'd0);
    chk("mrst_ack_data", data_o, 32'h0);
    chk("mrst_ack_inst", inst_o, NOP);
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h20;
    tick();
    inst_ce_i = 1'b0;
    chk("restart_req", 32'(mem_req_o), 32'd1);
    chk("restart_addr", mem_addr_o, 32'h20);
    mem_xfer(1, 32'h00308133);
    chk("restart_inst", inst_o, 32'h00308133);
    tick();
    tick();
    chk("restart_cnt", retire_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
